// File: rtl/m_issue_ctrl.sv
// Issues one M-extension instruction to a coprocessor and returns its result to the core.
// Optional WAIT-state timeout is compiled in with `define M_ISSUE_TIMEOUT_EN.
module m_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        valid,
    output logic [31:0] instruction,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    input  logic        wr,
    input  logic [31:0] rd,
    input  logic        busy,
    input  logic        ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        resp_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] insn_q, rs1_q, rs2_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic        is_m;
    logic        timeout_hit;
    logic        unused_ok;

    // busy is advisory only; it never steers the sequencer
    assign unused_ok = busy ^ (TIMEOUT_CYCLES == 0);

    // Decode runs on the captured word, so the ISSUE cycle doubles as the decode cycle
    assign is_m = (insn_q[6:0] == 7'h33) && (insn_q[31:25] == 7'h01);

`ifdef M_ISSUE_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (state_q == ISSUE) begin
            wait_cnt <= 8'd0;
        end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (wait_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = ISSUE;
            ISSUE: state_d = is_m ? WAIT : RESP;
            WAIT:  if (ready || timeout_hit) state_d = RESP;
            RESP:  if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            insn_q      <= 32'd0;
            rs1_q       <= 32'd0;
            rs2_q       <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                insn_q <= req_insn;
                rs1_q  <= req_rs1;
                rs2_q  <= req_rs2;
            end
            if (state_q == ISSUE && !is_m) begin
                resp_data_q <= 32'd0;
                resp_err_q  <= 1'b1;
            end
            // A result arriving on the expiry cycle takes priority over the timeout
            if (state_q == WAIT) begin
                if (ready) begin
                    resp_data_q <= rd;
                    resp_err_q  <= !wr;
                end else if (timeout_hit) begin
                    resp_data_q <= 32'd0;
                    resp_err_q  <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign valid       = (state_q == ISSUE) && is_m;
    assign instruction = insn_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;

endmodule

// File: doc/m_issue_ctrl.md
M_ISSUE_CTRL -- requirements
Module: m_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles waited for coprocessor ready before error, legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core offers an instruction.
REQ-005 SHALL have port req_ready  output  1  issuer accepts request (IDLE only).
REQ-006 SHALL have ports req_insn/req_rs1/req_rs2  input  32 each  instruction word and operands.
REQ-007 SHALL have ports valid output 1, instruction output 32, rs1 output 32, rs2 output 32  coprocessor issue bus.
REQ-008 SHALL have ports wr input 1, rd input 32, busy input 1, ready input 1  coprocessor result bus.
REQ-009 SHALL have ports resp_valid output 1, resp_data output 32, resp_err output 1, resp_ready input 1  result to core.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-011 IDLE: req_ready=1; req_valid=1 captures req_insn/rs1/rs2 into registers on that edge.
REQ-012 Captured insn is M-type iff bits[6:0]=7'h33 and bits[31:25]=7'h01; M-type goes to ISSUE, otherwise to RESP with resp_err=1, resp_data=0, no issue.
REQ-013 ISSUE: valid=1 for exactly one cycle with instruction/rs1/rs2 driven from captured registers; next state WAIT.
REQ-014 instruction/rs1/rs2 outputs SHALL hold captured values in ISSUE, WAIT and RESP; valid=0 in all states except ISSUE.
REQ-015 WAIT: on ready=1, capture rd into resp_data, resp_err=!wr, go to RESP.
REQ-016 ready=1 during the ISSUE cycle SHALL be ignored (unit result cannot precede issue edge).
REQ-017 busy is informational only; SHALL not alter transitions.
REQ-018 RESP: resp_valid=1, resp_data/resp_err stable until resp_ready=1; on resp_valid&&resp_ready go to IDLE.
REQ-019 Back-to-back: new request SHALL be accepted no earlier than the cycle after the RESP handshake; minimum issue-to-issue spacing 4 cycles.
REQ-020 Minimum latency request-accept to resp_valid: 3 cycles when ready rises the cycle after ISSUE.
REQ-021 req_ready SHALL be combinationally 1 only in IDLE; no other output depends combinationally on inputs.

Reset
REQ-022 reset=1 SHALL immediately force state IDLE, valid=0, resp_valid=0, resp_err=0, resp_data=0, instruction/rs1/rs2=0, timeout counter=0.
REQ-023 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abandon the transaction; a later ready pulse in IDLE SHALL be ignored.
REQ-024 First request SHALL be accepted on the first rising edge after reset deasserts with req_valid=1.

Configuration
REQ-025 Macro M_ISSUE_TIMEOUT_EN SHALL enable an 8-bit WAIT-state cycle counter, cleared on entering WAIT.
REQ-026 With M_ISSUE_TIMEOUT_EN defined: counter reaching TIMEOUT_CYCLES without ready SHALL go to RESP with resp_err=1, resp_data=0; ready in the same cycle as expiry wins (normal result).
REQ-027 Without M_ISSUE_TIMEOUT_EN: no counter logic synthesized; WAIT lasts indefinitely until ready.

Verification
REQ-028 MUL insn 32'h02000033, rs1=32'h1111FFFF, rs2=32'h1111FFFF, unit returns ready+wr -> resp_data=32'hDDDC0001, resp_err=0, valid high exactly one cycle.
REQ-029 Non-M insn 32'h00000033 (ADD) -> no valid pulse, resp_valid with resp_err=1, resp_data=0, 2 cycles after accept.
REQ-030 DIVU 32'h0200D033 with ready delayed 33 cycles and resp_ready held low 5 cycles -> resp_data/resp_err stable throughout, req_ready=0 until handshake.
REQ-031 M_ISSUE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, ready never asserted -> resp_err=1 after 8 WAIT cycles; undefined -> remains in WAIT after 100 cycles.
REQ-032 reset asserted during WAIT, then ready pulsed -> all outputs at reset values, no resp_valid; next request completes normally.
REQ-033 Two back-to-back REM requests (32'hFFFFFFF3 % 5, 5 % 32'hFFFFFFF3) with resp_ready=1 -> results 32'hFFFFFFFD then 32'h00000005, second valid pulse 4+ cycles after first.
